// File: rtl/hs_pkg.sv
// Shared types and defaults for the req/ack handshake transmit side.
// Default sizes are shared with the synchronizer bench.
package hs_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } hs_state_e;

  localparam int HS_WIDTH = 8;
  localparam int HS_DEPTH = 4;
  localparam int HS_CNT_W = 16;

endpackage

// File: rtl/handshake_tx_ctrl_if.sv
// Upstream stream plus synchronizer source-side signals.
// The controller is the slave; upstream and synchronizer form the master.
interface hs_tx_if
  import hs_pkg::*;
#(
  parameter int WIDTH = HS_WIDTH
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             sidle;
  logic             sready;
  logic [WIDTH-1:0] din;

  modport master (
    output in_valid, in_data, sidle,
    input  in_ready, sready, din
  );

  modport slave (
    input  in_valid, in_data, sidle,
    output in_ready, sready, din
  );
endinterface

// File: rtl/hs_sync_fifo.sv
// Synchronous show-ahead FIFO; push when full and pop when empty
// are both ignored.
module hs_sync_fifo
  import hs_pkg::*;
#(
  parameter  int WIDTH = HS_WIDTH,
  parameter  int DEPTH = HS_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign do_push = push_i && (cnt_q != CW'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);
  assign head_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/handshake_tx_ctrl.sv
// Source-side driver for the req/ack synchronizer: buffers words and
// issues one per transfer, holding din until the synchronizer is idle again.
module handshake_tx_ctrl
  import hs_pkg::*;
#(
  parameter  int WIDTH = HS_WIDTH,
  parameter  int DEPTH = HS_DEPTH,
  parameter  int CNT_W = HS_CNT_W,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  hs_tx_if.slave           bus,
  output logic [CW-1:0]    fifo_cnt,
  output logic [CNT_W-1:0] tx_count
);

  hs_state_e        state_q, state_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [CNT_W-1:0] tx_q, tx_d;
  logic             sready_q, sready_d;
  logic             push, pop;
  logic [WIDTH-1:0] head;
  logic [CW-1:0]    cnt;

  assign bus.in_ready = (cnt != CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign bus.sready   = sready_q;
  assign bus.din      = din_q;
  assign fifo_cnt     = cnt;
  assign tx_count     = tx_q;

  hs_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (bus.in_data),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (cnt)
  );

  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cnt != '0 && bus.sidle) begin
          state_d = REQ;
          din_d   = head;
        end
      end
      REQ: state_d = WAIT_LOW;
      // sidle is still stale-high here; only its fall arms completion
      WAIT_LOW: begin
        if (!bus.sidle) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (bus.sidle) begin
          pop     = 1'b1;
          tx_d    = tx_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    sready_d = (state_d == REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      din_q    <= '0;
      tx_q     <= '0;
      sready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      din_q    <= din_d;
      tx_q     <= tx_d;
      sready_q <= sready_d;
    end
  end

endmodule

// File: tb/tb_handshake_tx_ctrl.sv
// Bench for handshake_tx_ctrl against a behavioural synchronizer model
// whose busy time is programmable; delivered words go to a scoreboard.
module tb_handshake_tx_ctrl;
  import hs_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] fifo_cnt;
  logic [3:0] tx_count;

  hs_tx_if #(.WIDTH(HS_WIDTH)) bus();

  handshake_tx_ctrl #(
    .WIDTH (HS_WIDTH),
    .DEPTH (4),
    .CNT_W (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .fifo_cnt (fifo_cnt),
    .tx_count (tx_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int viol = 0;
  int nsready = 0;
  int exp_tx = 0;
  int lat = 0;
  int hold = 0;
  logic sidle_m;
  logic ovr = 1'b0;
  logic in_xfer = 1'b0;
  logic seen_low = 1'b0;
  logic prev_sready = 1'b0;
  logic [7:0] xfer_din;
  logic [7:0] exp_q[$];
  logic [7:0] dout_q[$];

  // ovr pins sidle low to hold the controller in IDLE
  assign bus.sidle = sidle_m && !ovr;

  // synchronizer model: drops sidle one cycle after sready, busy lat+1 cycles
  always @(posedge clk) begin
    if (rst) begin
      sidle_m <= 1'b1;
      hold    <= 0;
    end else if (bus.sready) begin
      sidle_m <= 1'b0;
      hold    <= lat;
    end else if (!sidle_m) begin
      if (hold == 0) sidle_m <= 1'b1;
      else hold <= hold - 1;
    end
  end

  // protocol monitor: captures issued words, flags protocol violations
  always @(negedge clk) begin
    if (rst) begin
      in_xfer     = 1'b0;
      seen_low    = 1'b0;
      prev_sready = 1'b0;
    end else begin
      if (bus.sready) begin
        if (prev_sready || !bus.sidle || in_xfer) viol++;
        in_xfer  = 1'b1;
        seen_low = 1'b0;
        xfer_din = bus.din;
        dout_q.push_back(bus.din);
        nsready++;
      end else if (in_xfer) begin
        if (bus.din !== xfer_din) viol++;
        if (!bus.sidle) seen_low = 1'b1;
        else if (seen_low) in_xfer = 1'b0;
      end
      prev_sready = bus.sready;
    end
  end

  task automatic push_word(input logic [7:0] d, output bit acc);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    acc = bus.in_ready;
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    logic [7:0] g, e;
    n = 0;
    while (n < budget && (exp_q.size() != 0 || in_xfer ||
           fifo_cnt != 0 || dout_q.size() != 0)) begin
      @(negedge clk);
      n++;
      while (dout_q.size() != 0) begin
        g = dout_q.pop_front();
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL dout_extra: got %02h, none expected", g);
        end else begin
          e = exp_q.pop_front();
          exp_tx = (exp_tx + 1) % 16;
          if (g !== e) begin
            fails++;
            $display("FAIL dout: got %02h expected %02h", g, e);
          end
        end
      end
    end
    tests++;
    if (n >= budget) begin
      fails++;
      $display("FAIL drain_timeout: %0d cycles, %0d words left",
               n, exp_q.size());
    end
  endtask

  task automatic check_tx(input string nm);
    tests++;
    if (tx_count !== 4'(exp_tx)) begin
      fails++;
      $display("FAIL %s tx_count: got %0d expected %0d",
               nm, tx_count, exp_tx);
    end
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests += 5;
    if (bus.sready !== 1'b0) begin
      fails++; $display("FAIL rst_sready: got %b expected 0", bus.sready);
    end
    if (bus.din !== 8'h00) begin
      fails++; $display("FAIL rst_din: got %02h expected 00", bus.din);
    end
    if (bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready);
    end
    if (fifo_cnt !== 3'd0) begin
      fails++; $display("FAIL rst_fifo_cnt: got %0d expected 0", fifo_cnt);
    end
    if (tx_count !== 4'd0) begin
      fails++; $display("FAIL rst_tx_count: got %0d expected 0", tx_count);
    end
  endtask

  task automatic test_single;
    bit acc;
    push_word(8'hA5, acc);
    tests++;
    if (acc !== 1'b1) begin
      fails++; $display("FAIL single_accept: got %b expected 1", acc);
    end
    @(negedge clk);
    tests += 2;
    if (bus.sready !== 1'b0) begin
      fails++; $display("FAIL single_early_sready: got %b expected 0", bus.sready);
    end
    if (fifo_cnt !== 3'd1) begin
      fails++; $display("FAIL single_cnt: got %0d expected 1", fifo_cnt);
    end
    @(negedge clk);
    tests += 2;
    if (bus.sready !== 1'b1) begin
      fails++; $display("FAIL single_sready: got %b expected 1", bus.sready);
    end
    if (bus.din !== 8'hA5) begin
      fails++; $display("FAIL single_din: got %02h expected a5", bus.din);
    end
    drain(100);
    check_tx("single");
    tests += 2;
    if (fifo_cnt !== 3'd0) begin
      fails++; $display("FAIL single_cnt_end: got %0d expected 0", fifo_cnt);
    end
    if (bus.din !== 8'hA5) begin
      fails++; $display("FAIL single_din_idle: got %02h expected a5", bus.din);
    end
  endtask

  task automatic test_back_to_back;
    bit acc;
    int ns0;
    ns0 = nsready;
    @(negedge clk);
    ovr = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push_word(8'(i), acc);
      tests++;
      if (acc !== 1'b1) begin
        fails++; $display("FAIL b2b_accept%0d: got %b expected 1", i, acc);
      end
    end
    @(negedge clk);
    tests += 3;
    if (bus.in_ready !== 1'b0) begin
      fails++; $display("FAIL b2b_full_ready: got %b expected 0", bus.in_ready);
    end
    if (fifo_cnt !== 3'd4) begin
      fails++; $display("FAIL b2b_cnt: got %0d expected 4", fifo_cnt);
    end
    if (nsready !== ns0) begin
      fails++; $display("FAIL b2b_idle_sready: got %0d expected %0d", nsready, ns0);
    end
    push_word(8'h05, acc);
    tests++;
    if (acc !== 1'b0) begin
      fails++; $display("FAIL b2b_fifth: got %b expected 0", acc);
    end
    ovr = 1'b0;
    drain(200);
    check_tx("b2b");
  endtask

  task automatic test_busy_hold;
    bit acc;
    int ns0;
    ns0 = nsready;
    lat = 50;
    push_word(8'h5A, acc);
    repeat (30) @(negedge clk);
    tests += 4;
    if (fifo_cnt !== 3'd1) begin
      fails++; $display("FAIL busy_cnt: got %0d expected 1", fifo_cnt);
    end
    if (tx_count !== 4'(exp_tx)) begin
      fails++; $display("FAIL busy_tx: got %0d expected %0d", tx_count, exp_tx);
    end
    if (nsready !== ns0 + 1) begin
      fails++; $display("FAIL busy_sready: got %0d expected %0d", nsready, ns0 + 1);
    end
    if (bus.din !== 8'h5A) begin
      fails++; $display("FAIL busy_din: got %02h expected 5a", bus.din);
    end
    drain(200);
    lat = 0;
    check_tx("busy");
    tests++;
    if (nsready !== ns0 + 1) begin
      fails++; $display("FAIL busy_sready_end: got %0d expected %0d", nsready, ns0 + 1);
    end
  endtask

  task automatic test_full_pop;
    bit acc;
    int n;
    logic [7:0] fill [4];
    fill = '{8'h11, 8'h22, 8'h33, 8'h44};
    @(negedge clk);
    ovr = 1'b1;
    for (int i = 0; i < 4; i++) push_word(fill[i], acc);
    lat = 3;
    @(negedge clk);
    tests++;
    if (fifo_cnt !== 3'd4) begin
      fails++; $display("FAIL fullpop_pre: got %0d expected 4", fifo_cnt);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    ovr = 1'b0;
    n = 0;
    while (n < 100 && fifo_cnt == 3'd4) begin
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    tests += 2;
    if (fifo_cnt !== 3'd3) begin
      fails++; $display("FAIL fullpop_cnt: got %0d expected 3", fifo_cnt);
    end
    if (bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL fullpop_ready: got %b expected 1", bus.in_ready);
    end
    drain(300);
    lat = 0;
    check_tx("fullpop");
  endtask

  task automatic test_idle_stall;
    bit acc;
    int ns0;
    @(negedge clk);
    ovr = 1'b1;
    ns0 = nsready;
    push_word(8'h3C, acc);
    repeat (10) @(negedge clk);
    tests += 2;
    if (nsready !== ns0) begin
      fails++; $display("FAIL stall_sready: got %0d expected %0d", nsready, ns0);
    end
    if (fifo_cnt !== 3'd1) begin
      fails++; $display("FAIL stall_cnt: got %0d expected 1", fifo_cnt);
    end
    ovr = 1'b0;
    drain(100);
    check_tx("stall");
  endtask

  task automatic test_reset_mid;
    bit acc;
    int n;
    int ns0;
    lat = 20;
    push_word(8'h66, acc);
    push_word(8'h77, acc);
    n = 0;
    while (n < 50 && !(in_xfer && seen_low)) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 50) begin
      fails++; $display("FAIL rstmid_wait: got timeout expected WAIT_HIGH");
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    dout_q.delete();
    exp_tx = 0;
    lat = 0;
    @(negedge clk);
    tests += 5;
    if (bus.sready !== 1'b0) begin
      fails++; $display("FAIL rstmid_sready: got %b expected 0", bus.sready);
    end
    if (bus.din !== 8'h00) begin
      fails++; $display("FAIL rstmid_din: got %02h expected 00", bus.din);
    end
    if (fifo_cnt !== 3'd0) begin
      fails++; $display("FAIL rstmid_cnt: got %0d expected 0", fifo_cnt);
    end
    if (tx_count !== 4'd0) begin
      fails++; $display("FAIL rstmid_tx: got %0d expected 0", tx_count);
    end
    if (bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL rstmid_ready: got %b expected 1", bus.in_ready);
    end
    ns0 = nsready;
    repeat (5) @(negedge clk);
    tests++;
    if (nsready !== ns0) begin
      fails++; $display("FAIL rstmid_no_issue: got %0d expected %0d", nsready, ns0);
    end
  endtask

  task automatic test_wrap;
    bit acc;
    int r;
    for (int i = 0; i < 17; i++) begin
      acc = 1'b0;
      r = 0;
      while (!acc && r < 100) begin
        push_word(8'(i * 7 + 3), acc);
        r++;
      end
      tests++;
      if (!acc) begin
        fails++; $display("FAIL wrap_push%0d: got rejected expected accepted", i);
      end
    end
    drain(2000);
    check_tx("wrap");
    tests++;
    if (tx_count !== 4'd1) begin
      fails++; $display("FAIL wrap_value: got %0d expected 1", tx_count);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_hold();
    test_full_pop();
    test_idle_stall();
    test_reset_mid();
    test_wrap();
    tests++;
    if (viol !== 0) begin
      fails++; $display("FAIL protocol: got %0d violations expected 0", viol);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
